// File: rtl/dot_product_engine.sv
// Dot-product engine: pops signed operand pairs from two upstream FIFOs,
// accumulates their products and presents the sum with a valid/ready handshake.
module dot_product_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  a_empty,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_rden,
  output logic                  b_rden,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     issued_q;
  logic [LEN_W-1:0]     accepted_q;
  logic                 data_vld_q;
  logic [ACC_WIDTH-1:0] acc_q;

  logic                           rden;
  logic                           start_accept;
  logic                           last_accum;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;

  // Pop both FIFOs together while pairs remain outstanding and both have data.
  always_comb begin
    rden         = (state_q == StRun) && !a_empty && !b_empty && (issued_q < len_q);
    start_accept = (state_q == StIdle) && start;
    // Accepted count is compared before increment, so len_q-1 marks the final product.
    last_accum   = data_vld_q && (accepted_q == len_q - LEN_W'(1));
    prod         = $signed(a_data) * $signed(b_data);
    prod_ext     = ACC_WIDTH'(prod);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (len != '0) ? StRun : StDone;
      end
      StRun: begin
        if (last_accum) state_d = StDone;
      end
      StDone: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Length latch, issue/accept counters, read-data-valid flag and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      data_vld_q <= 1'b0;
      acc_q      <= '0;
    end else if (start_accept) begin
      len_q      <= len;
      issued_q   <= '0;
      accepted_q <= '0;
      data_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      // FIFO data arrives one cycle after the pop.
      data_vld_q <= rden;
      if (rden) issued_q <= issued_q + LEN_W'(1);
      if (data_vld_q) begin
        accepted_q <= accepted_q + LEN_W'(1);
        acc_q      <= acc_q + prod_ext;
      end
    end
  end

  // Outputs.
  always_comb begin
    a_rden       = rden;
    b_rden       = rden;
    result       = acc_q;
    result_valid = (state_q == StDone);
    busy         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed testbench for dot_product_engine with a simple behavioural FIFO model.
module tb_dot_product_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        a_empty;
  logic        b_empty;
  logic [7:0]  a_data;
  logic [7:0]  b_data;
  logic        a_rden;
  logic        b_rden;
  logic [19:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  dot_product_engine #(
    .DATA_WIDTH(8),
    .ACC_WIDTH (20),
    .LEN_W     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .a_empty     (a_empty),
    .b_empty     (b_empty),
    .a_data      (a_data),
    .b_data      (b_data),
    .a_rden      (a_rden),
    .b_rden      (b_rden),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: append-only storage, read pointers advance on pop.
  logic [7:0] a_mem [0:1023];
  logic [7:0] b_mem [0:1023];
  int         a_cnt = 0;
  int         b_cnt = 0;
  int         a_rp  = 0;
  int         b_rp  = 0;
  logic       b_block = 1'b0;

  assign a_empty = (a_rp >= a_cnt);
  assign b_empty = (b_rp >= b_cnt) || b_block;

  // Pop data appears on the read-data bus one cycle after rden.
  always @(posedge clk) begin
    if (a_rden) begin
      a_data <= a_mem[a_rp];
      a_rp   <= a_rp + 1;
    end
    if (b_rden) begin
      b_data <= b_mem[b_rp];
      b_rp   <= b_rp + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    a_mem[a_cnt] = a;
    b_mem[b_cnt] = b;
    a_cnt++;
    b_cnt++;
  endtask

  // Launch one operation and follow it to result_valid; cycle 0 holds start.
  // b_block stalls FIFO-B during cycles stall_lo..stall_hi. Returns with the
  // clock at the negedge of the first result_valid cycle.
  task automatic run_op(input string tag, input logic [7:0] n, input logic [19:0] exp_res,
                        input int exp_vc, input logic check_mask, input logic [15:0] exp_mask,
                        input int stall_lo, input int stall_hi);
    int         cyc;
    int         vc;
    int         pops;
    logic [15:0] mask;
    @(negedge clk);
    start = 1'b1;
    len   = n;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 1;
    vc      = -1;
    pops    = 0;
    mask    = '0;
    b_block = (cyc >= stall_lo) && (cyc <= stall_hi);
    while (vc < 0 && cyc < 600) begin
      @(negedge clk);
      if (a_rden !== b_rden) check_eq({tag, "_rden_eq"}, {31'b0, b_rden}, {31'b0, a_rden});
      if (a_rden) begin
        pops++;
        if (cyc < 16) mask[cyc] = 1'b1;
      end
      if (result_valid) begin
        vc = cyc;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        b_block = (cyc >= stall_lo) && (cyc <= stall_hi);
      end
    end
    b_block = 1'b0;
    check_eq({tag, "_valid_cycle"}, vc, exp_vc);
    check_eq({tag, "_result"}, {12'b0, result}, {12'b0, exp_res});
    check_eq({tag, "_pops"}, pops, {24'b0, n});
    if (check_mask) check_eq({tag, "_rden_mask"}, {16'b0, mask}, {16'b0, exp_mask});
  endtask

  // Accept the result and confirm IDLE with the result retained.
  task automatic accept(input string tag, input logic [19:0] exp_res);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_idle_valid"}, {31'b0, result_valid}, 32'd0);
    check_eq({tag, "_idle_hold"}, {12'b0, result}, {12'b0, exp_res});
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    len          = '0;
    result_ready = 1'b0;
    a_data       = '0;
    b_data       = '0;
    #12;
    check_eq("rst_rden", {31'b0, a_rden | b_rden}, 32'd0);
    check_eq("rst_result", {12'b0, result}, 32'd0);
    check_eq("rst_valid", {31'b0, result_valid}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1*4 + 2*5 + 3*6 = 32
    push(8'd1, 8'd4);
    push(8'd2, 8'd5);
    push(8'd3, 8'd6);
    run_op("len3", 8'd3, 20'd32, 5, 1'b1, 16'h000E, -1, -1);
    accept("len3", 20'd32);

    // -3 * 7 = -21
    push(8'hFD, 8'd7);
    run_op("neg", 8'd1, 20'hFFFEB, 3, 1'b1, 16'h0002, -1, -1);
    accept("neg", 20'hFFFEB);

    // 1*5 - 2*6 - 3*7 + 4*8 = 4; B stalled in cycles 3..4
    push(8'd1, 8'd5);
    push(8'hFE, 8'd6);
    push(8'd3, 8'hF9);
    push(8'd4, 8'd8);
    run_op("stall", 8'd4, 20'd4, 8, 1'b1, 16'h0066, 3, 4);
    accept("stall", 20'd4);

    run_op("len0", 8'd0, 20'd0, 1, 1'b1, 16'h0000, -1, -1);
    accept("len0", 20'd0);

    // 255 * 16384 = 0x3FC000, wraps to 0xFC000
    for (int i = 0; i < 255; i++) push(8'h80, 8'h80);
    run_op("len255", 8'd255, 20'hFC000, 257, 1'b0, 16'h0000, -1, -1);
    accept("len255", 20'hFC000);

    // 127*127 + (-128)*(-128) = 32513; consumer stalls 5 cycles while start is pulsed
    push(8'd127, 8'd127);
    push(8'h80, 8'h80);
    run_op("hold", 8'd2, 20'd32513, 4, 1'b1, 16'h0006, -1, -1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      len   = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("hold_valid", {31'b0, result_valid}, 32'd1);
      check_eq("hold_result", {12'b0, result}, 32'd32513);
      check_eq("hold_rden", {31'b0, a_rden}, 32'd0);
    end
    accept("hold", 20'd32513);
    @(negedge clk);
    check_eq("hold_no_restart", {31'b0, busy}, 32'd0);

    // Reset mid-RUN abandons the operation.
    for (int i = 0; i < 6; i++) push(8'd2, 8'd3);
    @(negedge clk);
    start = 1'b1;
    len   = 8'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_rden", {31'b0, a_rden | b_rden}, 32'd0);
    check_eq("arst_busy", {31'b0, busy}, 32'd0);
    check_eq("arst_result", {12'b0, result}, 32'd0);
    check_eq("arst_valid", {31'b0, result_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_valid", {31'b0, result_valid}, 32'd0);
    check_eq("post_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("post_rst_result", {12'b0, result}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
